ili9341_rect_fill: RTL and testbench
====================================

Name: ili9341_rect_fill

Overview:
- Wishbone master that sits directly upstream of the ILI9341 controller and drives its 8-bit slave port.
- Accepts a rectangle (x0,y0)-(x1,y1) and one RGB565 colour.
- Issues the column-address (0x2A), page-address (0x2B) and memory-write (0x2C) command/parameter bytes, then streams the colour once per pixel.
- Used for screen clears, solid fills and single-pixel plots.

Parameters:
TFT_WIDTH, 240, number of columns; valid x range 0..TFT_WIDTH-1
TFT_HEIGHT, 320, number of rows; valid y range 0..TFT_HEIGHT-1
RETRY_GAP, 4, idle cycles (STB_O low) after RTY_I before re-presenting the same byte

Ports:
CLK_I  in  1  system clock; all logic on posedge
RST_I  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
x0  in  9  left column
y0  in  9  top row
x1  in  9  right column, inclusive
y1  in  9  bottom row, inclusive
color  in  16  RGB565 fill colour
busy  out  1  high from the cycle after an accepted start until done/err
done  out  1  one-cycle pulse: whole rectangle written
err  out  1  one-cycle pulse: rectangle rejected, nothing sent
STB_O  out  1  wishbone strobe to controller
WE_O  out  1  write enable; always 1 while STB_O is high
ADR_O  out  8  0x00 = command byte (D/C low), 0x01 = data byte (D/C high)
DAT_O  out  8  byte to send
ACK_I  in  1  controller accepted byte
RTY_I  in  1  controller busy; retry

Behaviour:
- Reset (async, immediate): state=IDLE; STB_O, WE_O, ADR_O, DAT_O, busy, done and err are all 0; counters cleared. Reset mid-stream abandons the transfer with no done pulse.
- IDLE: on start=1, latch x0..color; go to CHECK. start in any other state is ignored and does not queue.
- CHECK (1 cycle):
  - Reject if x1<x0, y1<y0, x1>=TFT_WIDTH or y1>=TFT_HEIGHT: err=1 for one cycle, busy=0, return to IDLE, STB_O never asserted.
  - Otherwise compute pixel count N=(x1-x0+1)*(y1-y0+1) as 17-bit unsigned (max 76800), clear byte index, go to REQ.
- Byte sequence by index:
  - 0: ADR 0x00, 0x2A
  - 1-4: ADR 0x01, x0 hi, x0 lo, x1 hi, x1 lo (16-bit zero-extended, hi first)
  - 5: ADR 0x00, 0x2B
  - 6-9: ADR 0x01, y0 hi, y0 lo, y1 hi, y1 lo
  - 10: ADR 0x00, 0x2C
  - then 2N data bytes (ADR 0x01): color[15:8], color[7:0], repeated N times.
  - Total = 11 + 2N transactions.
- REQ: STB_O=1, WE_O=1, ADR_O/DAT_O driven from index; go to WAIT_ACK. ADR_O/DAT_O stay stable while STB_O is high.
- WAIT_ACK:
  - ACK_I=1: STB_O drops the next cycle. If this was the last byte, go to DONE; otherwise increment the index (or pixel byte phase/pixel counter) and go to REQ. There is at least one STB_O-low cycle between bytes.
  - RTY_I=1 with ACK_I=0: STB_O drops; go to BACKOFF.
  - ACK_I and RTY_I high together: treated as ACK.
  - Neither: hold with no timeout.
- BACKOFF: STB_O low for exactly RETRY_GAP cycles, then REQ with the same index and byte.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE. A start in the cycle after done is accepted.
- Pixel counter: counts down from N and stops at zero. The header is always sent, even for N=1.
- ACK_I/RTY_I outside WAIT_ACK are ignored.

Test Plan:
- Single pixel: x0=x1=5, y0=y1=7, color=0xF800, slave ACKs every byte after 1 cycle -> exactly 13 transactions (ADR,DAT):
  - (0,2A) (1,00)(1,05)(1,00)(1,05)
  - (0,2B) (1,00)(1,07)(1,00)(1,07)
  - (0,2C) (1,F8)(1,00)
  - then a done pulse; busy low afterwards.
- Full screen: 0,0,239,319, color=0x001F -> 153611 transactions; data bytes alternate 0x00/0x1F; x1 bytes 00,EF; y1 bytes 01,3F; single done pulse.
- Invalid rectangles: x0=10,x1=9 and, separately, y1=320 -> err pulse 2 cycles after start, STB_O never high, no done.
- Retry: slave returns RTY_I on byte index 3 twice, then ACK -> STB_O low for 4 cycles after each RTY; byte 3 re-presented as (1,00) for x1=5; sequence otherwise unchanged; ACK+RTY in the same cycle is counted as ACK.
- Start during busy: second start (different colour) mid-transfer -> ignored; only the first rectangle is written; one done pulse.
- Async reset: RST_I asserted during pixel data, between clock edges -> STB_O, busy and done are 0 immediately. After release, a new 2x1 fill produces 15 transactions from index 0.

Source files
------------

// File: rtl/ili9341_rect_fill.sv
// Rectangle fill engine: sends the ILI9341 window commands (0x2A/0x2B/0x2C)
// as 8-bit Wishbone writes, then streams one RGB565 colour per pixel.
module ili9341_rect_fill #(
    parameter int unsigned TFT_WIDTH  = 240,
    parameter int unsigned TFT_HEIGHT = 320,
    parameter int unsigned RETRY_GAP  = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  y0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        STB_O,
    output logic        WE_O,
    output logic [7:0]  ADR_O,
    output logic [7:0]  DAT_O,
    input  logic        ACK_I,
    input  logic        RTY_I
);

    localparam int unsigned CW = 9;
    localparam int unsigned PW = 17;
    localparam int unsigned IW = 4;
    localparam int unsigned GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_BACKOFF = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Index 11 is the pixel-data phase; everything below is header.
    localparam logic [IW-1:0] IDX_DATA = IW'(11);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [15:0]   color_q, color_d;
    logic [PW-1:0] npix_q, npix_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          phase_q, phase_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          stb_q, stb_d, we_q, we_d;
    logic [7:0]    adr_q, adr_d, dat_q, dat_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [7:0]    tx_adr_c, tx_dat_c;
    logic [CW-1:0] width_c, height_c;
    logic          rect_bad_c, last_c;

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign STB_O = stb_q;
    assign WE_O  = we_q;
    assign ADR_O = adr_q;
    assign DAT_O = dat_q;

    // Byte to present for the current index / pixel phase
    always_comb begin
        tx_adr_c = 8'h01;
        tx_dat_c = 8'h00;
        case (idx_q)
            IW'(0):  begin tx_adr_c = 8'h00; tx_dat_c = 8'h2A; end
            IW'(1):  tx_dat_c = {7'd0, x0_q[8]};
            IW'(2):  tx_dat_c = x0_q[7:0];
            IW'(3):  tx_dat_c = {7'd0, x1_q[8]};
            IW'(4):  tx_dat_c = x1_q[7:0];
            IW'(5):  begin tx_adr_c = 8'h00; tx_dat_c = 8'h2B; end
            IW'(6):  tx_dat_c = {7'd0, y0_q[8]};
            IW'(7):  tx_dat_c = y0_q[7:0];
            IW'(8):  tx_dat_c = {7'd0, y1_q[8]};
            IW'(9):  tx_dat_c = y1_q[7:0];
            IW'(10): begin tx_adr_c = 8'h00; tx_dat_c = 8'h2C; end
            default: tx_dat_c = phase_q ? color_q[7:0] : color_q[15:8];
        endcase
    end

    // Rectangle validation, size and last-byte detection
    always_comb begin
        width_c    = x1_q - x0_q + CW'(1);
        height_c   = y1_q - y0_q + CW'(1);
        rect_bad_c = (x1_q < x0_q) || (y1_q < y0_q) ||
                     (x1_q >= CW'(TFT_WIDTH)) || (y1_q >= CW'(TFT_HEIGHT));
        last_c     = (idx_q == IDX_DATA) && phase_q && (npix_q == PW'(1));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        npix_d  = npix_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    color_d = color;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rect_bad_c) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    npix_d  = PW'(width_c) * PW'(height_c);
                    idx_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = tx_adr_c;
                dat_d   = tx_dat_c;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ACK_I) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (last_c) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        if (idx_q != IDX_DATA) begin
                            idx_d = idx_q + IW'(1);
                        end else if (!phase_q) begin
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            npix_d  = (npix_q != '0) ? npix_q - PW'(1) : npix_q;
                        end
                        state_d = S_REQ;
                    end
                end else if (RTY_I) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    gap_d   = '0;
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                // Re-raise the strobe directly so the low window is exactly RETRY_GAP cycles
                if (gap_q == GW'(RETRY_GAP - 1)) begin
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            npix_q  <= '0;
            idx_q   <= '0;
            phase_q <= 1'b0;
            gap_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            npix_q  <= npix_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ili9341_rect_fill.sv
// Scoreboard bench: expected (ADR,DAT) bytes are queued at start and popped
// as the slave model ACKs each write.
module tb_ili9341_rect_fill;

    localparam int unsigned RETRY_GAP = 4;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic        start;
    logic [8:0]  x0, y0, x1, y1;
    logic [15:0] color;
    logic        busy, done, err;
    logic        STB_O, WE_O;
    logic [7:0]  ADR_O, DAT_O;
    logic        ACK_I, RTY_I;

    ili9341_rect_fill #(
        .TFT_WIDTH (240),
        .TFT_HEIGHT(320),
        .RETRY_GAP (RETRY_GAP)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .done(done), .err(err),
        .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
        .ACK_I(ACK_I), .RTY_I(RTY_I)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    int  txn_idx   = 0;
    int  done_cnt  = 0;
    int  stb_seen  = 0;
    int  stb_age   = 0;
    int  low_cnt   = 0;
    int  rty_left  = 0;
    int  gap_seen  = 0;
    bit  rty_mode  = 0;
    bit  after_rty = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave model: responds on the second cycle of each strobe, checks bytes
    always @(negedge CLK_I) begin
        logic [15:0] e;
        ACK_I = 1'b0;
        RTY_I = 1'b0;
        if (done) begin
            done_cnt++;
            check_eq("busy_at_done", int'(busy), 0);
        end
        if (STB_O) begin
            stb_seen++;
            if (after_rty) begin
                check_eq("retry_gap", low_cnt, int'(RETRY_GAP));
                gap_seen++;
                after_rty = 0;
            end
            low_cnt = 0;
            stb_age++;
            if (stb_age == 2) begin
                if (rty_mode && txn_idx == 3 && rty_left > 0) begin
                    RTY_I = 1'b1;
                    rty_left--;
                    after_rty = 1;
                    if (exp_q.size() > 0)
                        check_eq("retry_byte", int'({ADR_O, DAT_O}), int'(exp_q[0]));
                end else begin
                    ACK_I = 1'b1;
                    if (rty_mode && txn_idx == 3) RTY_I = 1'b1;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_txn", txn_idx, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("txn%0d", txn_idx), int'({ADR_O, DAT_O}), int'(e));
                        check_eq("we", int'(WE_O), 1);
                    end
                    txn_idx++;
                end
            end
        end else begin
            stb_age = 0;
            low_cnt++;
        end
    end

    task automatic push_rect(input logic [8:0] a, input logic [8:0] b,
                             input logic [8:0] c, input logic [8:0] d,
                             input logic [15:0] col);
        int n;
        exp_q.push_back(16'h002A);
        exp_q.push_back({8'h01, 7'd0, a[8]});
        exp_q.push_back({8'h01, a[7:0]});
        exp_q.push_back({8'h01, 7'd0, c[8]});
        exp_q.push_back({8'h01, c[7:0]});
        exp_q.push_back(16'h002B);
        exp_q.push_back({8'h01, 7'd0, b[8]});
        exp_q.push_back({8'h01, b[7:0]});
        exp_q.push_back({8'h01, 7'd0, d[8]});
        exp_q.push_back({8'h01, d[7:0]});
        exp_q.push_back(16'h002C);
        n = (int'(c) - int'(a) + 1) * (int'(d) - int'(b) + 1);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'h01, col[15:8]});
            exp_q.push_back({8'h01, col[7:0]});
        end
    endtask

    task automatic start_rect(input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] c, input logic [8:0] d,
                              input logic [15:0] col);
        @(posedge CLK_I);
        #1;
        x0 = a; y0 = b; x1 = c; y1 = d; color = col;
        txn_idx  = 0;
        done_cnt = 0;
        stb_seen = 0;
        start    = 1'b1;
        @(posedge CLK_I);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int ntx);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 5000) begin
            @(posedge CLK_I);
            c++;
        end
        repeat (3) @(posedge CLK_I);
        #1;
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_txns"}, txn_idx, ntx);
        check_eq({tag, "_queue_left"}, exp_q.size(), 0);
        check_eq({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic wait_txn(input int n);
        int c;
        c = 0;
        while (txn_idx < n && c < 2000) begin
            @(posedge CLK_I);
            c++;
        end
        check_eq("wait_txn", int'(txn_idx >= n), 1);
    endtask

    task automatic check_reject(input string tag);
        @(negedge CLK_I);
        check_eq({tag, "_err_early"}, int'({err, busy}), 1);
        @(negedge CLK_I);
        check_eq({tag, "_err_pulse"}, int'({err, busy}), 2);
        @(negedge CLK_I);
        check_eq({tag, "_err_clear"}, int'(err), 0);
        repeat (10) @(posedge CLK_I);
        #1;
        check_eq({tag, "_no_stb"}, stb_seen, 0);
        check_eq({tag, "_no_done"}, done_cnt, 0);
    endtask

    initial begin
        RST_I = 1'b1;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
        ACK_I = 1'b0;
        RTY_I = 1'b0;
        repeat (3) @(negedge CLK_I);
        check_eq("reset_outs", int'({STB_O, WE_O, ADR_O, DAT_O, busy, done, err}), 0);
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;

        // Single pixel
        push_rect(9'd5, 9'd7, 9'd5, 9'd7, 16'hF800);
        start_rect(9'd5, 9'd7, 9'd5, 9'd7, 16'hF800);
        wait_done("pixel", 13);

        // Bottom-right corner of the panel
        push_rect(9'd238, 9'd318, 9'd239, 9'd319, 16'h001F);
        start_rect(9'd238, 9'd318, 9'd239, 9'd319, 16'h001F);
        wait_done("corner", 19);

        // Rejected rectangles
        start_rect(9'd10, 9'd0, 9'd9, 9'd0, 16'h1111);
        check_reject("bad_x");
        start_rect(9'd0, 9'd0, 9'd0, 9'd320, 16'h2222);
        check_reject("bad_y");

        // Retry twice on byte 3, then ACK+RTY together
        rty_mode = 1;
        rty_left = 2;
        gap_seen = 0;
        push_rect(9'd5, 9'd7, 9'd5, 9'd7, 16'h1234);
        start_rect(9'd5, 9'd7, 9'd5, 9'd7, 16'h1234);
        wait_done("retry", 13);
        check_eq("retry_gaps_seen", gap_seen, 2);
        check_eq("retry_left", rty_left, 0);
        rty_mode = 0;

        // Second start while busy is ignored
        push_rect(9'd0, 9'd0, 9'd3, 9'd1, 16'hAAAA);
        start_rect(9'd0, 9'd0, 9'd3, 9'd1, 16'hAAAA);
        wait_txn(5);
        @(posedge CLK_I);
        #1;
        color = 16'h5555;
        x1    = 9'd9;
        start = 1'b1;
        @(posedge CLK_I);
        #1;
        start = 1'b0;
        wait_done("busy_start", 27);

        // Asynchronous reset in the middle of pixel data
        push_rect(9'd0, 9'd0, 9'd1, 9'd1, 16'hC3C3);
        start_rect(9'd0, 9'd0, 9'd1, 9'd1, 16'hC3C3);
        wait_txn(13);
        @(posedge CLK_I);
        #2;
        RST_I = 1'b1;
        #1;
        check_eq("async_rst", int'({STB_O, busy, done}), 0);
        exp_q.delete();
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        push_rect(9'd3, 9'd2, 9'd4, 9'd2, 16'h0F0F);
        start_rect(9'd3, 9'd2, 9'd4, 9'd2, 16'h0F0F);
        wait_done("after_rst", 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
